rom_port_arbiter: RTL and testbench
===================================

Name: rom_port_arbiter

Overview:
- Shares the single combinational-read instruction ROM (32-bit word array, indexed by addr[31:2]) between two requesters.
- M0 is the CPU instruction-fetch port; M1 is the data-load port, for constant tables in ROM and the debug/loader read-back.
- Sits between the RV32I core / APB load path and the ROM.
- Grants one request per cycle, returns read data registered one cycle after grant, flags out-of-range accesses, and prevents starvation of either port.

Parameters:
- ADDR_W, 32, requester byte-address width.
- ROM_DEPTH, 65536, ROM size in 32-bit words. Accesses with addr[31:2] >= ROM_DEPTH are out of range.
- MAX_WAIT, 4, consecutive cycles the losing requester may wait before it is force-granted (range 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- m0_req  in  1  fetch request; held with m0_addr stable until m0_gnt.
- m0_addr  in  ADDR_W  fetch byte address.
- m0_gnt  out  1  combinational grant, same cycle as req.
- m0_rvalid  out  1  response valid, one cycle after grant.
- m0_rdata  out  32  response data.
- m0_err  out  1  out-of-range flag, qualified by m0_rvalid.
- m1_req, m1_addr, m1_gnt, m1_rvalid, m1_rdata, m1_err: same as the m0 set, for the load port.
- rom_addr  out  32  byte address to ROM (ROM uses [31:2]).
- rom_data  in  32  ROM read word (combinational).

Behaviour:
- Reset (async, reset_n=0): all rvalid/err = 0, rdata = 0, wait counters = 0, priority pointer = M0, last_winner = M0.
- Grant logic (combinational):
  - Only one gnt per cycle.
  - rom_addr = granted requester's addr, else last granted addr (no toggling when idle).
  - Default policy is fixed priority M0 > M1, except as modified by the starvation counters.
- Starvation counters, one 4-bit counter per port:
  - Counter increments each cycle the port has req=1 and no gnt.
  - Counter clears on that port's gnt or when req=0.
  - When a counter reaches MAX_WAIT, that port wins next, overriding priority.
  - If both counters reach MAX_WAIT in the same cycle, the port that is not last_winner wins.
  - Counters saturate at 15.
- Response:
  - On the clock edge after a grant to Mx: mx_rvalid=1 for exactly one cycle.
  - mx_rdata = rom_data sampled at grant; mx_err = out-of-range flag of the granted addr.
  - If err=1, rdata = 32'h0000_0013 (NOP) so a fetch of unmapped space executes harmlessly.
  - Otherwise rdata holds its last value between responses.
- Misaligned addr (addr[1:0] != 0): word-aligned read by truncation, no error.
- Back-to-back: a requester that keeps req high may be granted every cycle; responses are pipelined, 1 per cycle, latency 1.
- Simultaneous req, fixed mode, no starvation: M0 granted, M1 counter increments.
- Reset mid-transaction: pending response dropped, rvalid forced 0 immediately; requesters must re-issue.
- req deasserted before gnt: legal; no response is generated and that port's counter clears.

Optional Feature:
- Macro: ROM_ARB_RR_EN.
- Defined: fixed priority replaced by round-robin. On simultaneous requests, the port that is not last_winner wins; starvation counters still operate and override.
- Undefined: fixed priority M0 > M1 with MAX_WAIT starvation override, as above.

Test Plan:
- Reset, then M0 req addr 0x0000_0008 with ROM word[2]=0x0011_2023 -> m0_gnt same cycle; next cycle m0_rvalid=1, m0_rdata=0x0011_2023, m0_err=0; m1 outputs stay 0.
- M0 and M1 both req continuously, MAX_WAIT=4, fixed mode -> M0 granted 4 cycles, M1 granted on cycle 5, then M0 again. M1 rvalid pulses exactly one cycle after each of its grants.
- Same stimulus with ROM_ARB_RR_EN defined -> grants alternate M0, M1, M0, M1, ...; each rdata matches the ROM word of its own addr.
- M1 req addr 0x0004_0000 (word 65536 >= ROM_DEPTH) -> m1_rvalid=1, m1_err=1, m1_rdata=0x0000_0013.
- M0 streams addresses 0, 4, 8, 12 every cycle -> four consecutive rvalid cycles carrying ROM words 0..3 in order; rom_addr then holds 0x0000_000C while idle.
- Assert reset_n=0 in the cycle after an M1 grant -> m1_rvalid is 0 immediately and stays 0 after reset release; counters read 0; first post-reset grant with both requesting goes to M0.

Source files
------------

// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: shares one combinational-read instruction ROM between
// the CPU fetch port (M0) and the data-load port (M1).
// One grant per cycle, with a combinational grant and a registered response
// one cycle later. Out-of-range reads return a NOP word and set err.
// Per-port starvation counters force a grant after MAX_WAIT cycles of waiting.
// Build option: define ROM_ARB_RR_EN to replace fixed M0 > M1 priority with
// round-robin on simultaneous requests. Starvation override applies in both modes.
module rom_port_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int ROM_DEPTH = 65536,
    parameter int MAX_WAIT  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [31:0]       m0_rdata,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [31:0]       m1_rdata,
    output logic              m1_err,
    output logic [31:0]       rom_addr,
    input  logic [31:0]       rom_data
);

    localparam logic [31:0] NOP_WORD   = 32'h0000_0013;
    localparam logic [3:0]  WAIT_LIMIT = 4'(MAX_WAIT);

    typedef enum logic {PORT_M0 = 1'b0, PORT_M1 = 1'b1} port_t;

    // Word index is addr[ADDR_W-1:2]; widened so any ROM_DEPTH compares cleanly
    function automatic logic out_of_range(input logic [ADDR_W-1:0] addr);
        logic [63:0] word_idx;
        word_idx = 64'(addr[ADDR_W-1:2]);
        return (word_idx >= 64'(ROM_DEPTH));
    endfunction

    function automatic logic [31:0] to_rom_addr(input logic [ADDR_W-1:0] addr);
        return 32'(addr);
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] cnt);
        return (cnt == 4'hF) ? cnt : cnt + 4'd1;
    endfunction

    // Unmapped fetches must execute harmlessly, so they read back a NOP
    function automatic logic [31:0] resp_word(input logic err, input logic [31:0] word);
        return err ? NOP_WORD : word;
    endfunction

    logic [3:0]  r_cnt0;
    logic [3:0]  r_cnt1;
    port_t       r_last_winner;
    logic [31:0] r_last_addr;
    logic        r_m0_rvalid;
    logic        r_m1_rvalid;
    logic [31:0] r_m0_rdata;
    logic [31:0] r_m1_rdata;
    logic        r_m0_err;
    logic        r_m1_err;

    logic        w_starve0;
    logic        w_starve1;
    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_oor0;
    logic        w_oor1;
    logic [31:0] w_rom_addr;

    assign w_starve0 = m0_req && (r_cnt0 >= WAIT_LIMIT);
    assign w_starve1 = m1_req && (r_cnt1 >= WAIT_LIMIT);
    assign w_oor0    = out_of_range(m0_addr);
    assign w_oor1    = out_of_range(m1_addr);

    // Pick at most one winner: starvation first, then the base policy
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (w_starve0 && w_starve1) begin
            if (r_last_winner == PORT_M0) w_gnt1 = 1'b1;
            else                          w_gnt0 = 1'b1;
        end else if (w_starve0) begin
            w_gnt0 = 1'b1;
        end else if (w_starve1) begin
            w_gnt1 = 1'b1;
        end else if (m0_req && m1_req) begin
`ifdef ROM_ARB_RR_EN
            if (r_last_winner == PORT_M0) w_gnt1 = 1'b1;
            else                          w_gnt0 = 1'b1;
`else
            w_gnt0 = 1'b1;
`endif
        end else if (m0_req) begin
            w_gnt0 = 1'b1;
        end else if (m1_req) begin
            w_gnt1 = 1'b1;
        end
    end

    // ROM address follows the winner and holds the last granted address when idle
    always_comb begin
        w_rom_addr = r_last_addr;
        if (w_gnt0)      w_rom_addr = to_rom_addr(m0_addr);
        else if (w_gnt1) w_rom_addr = to_rom_addr(m1_addr);
    end

    // Starvation counters: count waiting cycles, clear on grant or dropped request
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt0 <= 4'd0;
            r_cnt1 <= 4'd0;
        end else begin
            r_cnt0 <= (m0_req && !w_gnt0) ? sat_inc(r_cnt0) : 4'd0;
            r_cnt1 <= (m1_req && !w_gnt1) ? sat_inc(r_cnt1) : 4'd0;
        end
    end

    // Remember the last winner and its address for tie-break and idle rom_addr
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_winner <= PORT_M0;
            r_last_addr   <= 32'd0;
        end else if (w_gnt0) begin
            r_last_winner <= PORT_M0;
            r_last_addr   <= w_rom_addr;
        end else if (w_gnt1) begin
            r_last_winner <= PORT_M1;
            r_last_addr   <= w_rom_addr;
        end
    end

    // Response stage: one-cycle rvalid pulse, data captured at grant and held after
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_m0_rvalid <= 1'b0;
            r_m1_rvalid <= 1'b0;
            r_m0_rdata  <= 32'd0;
            r_m1_rdata  <= 32'd0;
            r_m0_err    <= 1'b0;
            r_m1_err    <= 1'b0;
        end else begin
            r_m0_rvalid <= w_gnt0;
            r_m1_rvalid <= w_gnt1;
            if (w_gnt0) begin
                r_m0_err   <= w_oor0;
                r_m0_rdata <= resp_word(w_oor0, rom_data);
            end
            if (w_gnt1) begin
                r_m1_err   <= w_oor1;
                r_m1_rdata <= resp_word(w_oor1, rom_data);
            end
        end
    end

    assign m0_gnt    = w_gnt0;
    assign m1_gnt    = w_gnt1;
    assign rom_addr  = w_rom_addr;
    assign m0_rvalid = r_m0_rvalid;
    assign m1_rvalid = r_m1_rvalid;
    assign m0_rdata  = r_m0_rdata;
    assign m1_rdata  = r_m1_rdata;
    assign m0_err    = r_m0_err;
    assign m1_err    = r_m1_err;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Testbench for rom_port_arbiter: directed vector table, reset-mid-transaction
// sequence and randomized traffic against a behavioural reference model.
module tb_rom_port_arbiter;

    localparam int MAX_WAIT  = 4;
    localparam int ROM_DEPTH = 65536;
`ifdef ROM_ARB_RR_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        m0_req = 1'b0;
    logic [31:0] m0_addr = 32'd0;
    logic        m0_gnt, m0_rvalid, m0_err;
    logic [31:0] m0_rdata;
    logic        m1_req = 1'b0;
    logic [31:0] m1_addr = 32'd0;
    logic        m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m1_rdata;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;

    rom_port_arbiter #(.ADDR_W(32), .ROM_DEPTH(ROM_DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_gnt(m0_gnt),
        .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_gnt(m1_gnt),
        .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .rom_addr(rom_addr), .rom_data(rom_data)
    );

    always #5 clk = ~clk;

    // ROM contents: word 2 is the documented store instruction, the rest a hash
    function automatic logic [31:0] rom_fn(input logic [31:0] a);
        logic [31:0] idx;
        idx = {2'b00, a[31:2]};
        if (idx == 32'd2) return 32'h0011_2023;
        return (idx * 32'h9E37_79B1) ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [31:0] w(input int i);
        return rom_fn(32'(i) << 2);
    endfunction

    assign rom_data = rom_fn(rom_addr);

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    int          mw[2];
    int          m_last;
    logic [31:0] m_last_addr;
    logic        e_rv[2];
    logic [31:0] e_rd[2];
    logic        e_er[2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mw[k] = 0; e_rv[k] = 1'b0; e_rd[k] = 32'd0; e_er[k] = 1'b0;
        end
        m_last = 0;
        m_last_addr = 32'd0;
    endtask

    task automatic model_step(input logic q0, input logic [31:0] a0,
                              input logic q1, input logic [31:0] a1, output int win);
        logic        q[2];
        logic [31:0] a[2];
        bit          s[2];
        logic [31:0] exp_rom;
        logic [31:0] act_rv[2];
        logic [31:0] act_rd[2];
        logic [31:0] act_er[2];
        logic        oor;
        q[0] = q0; q[1] = q1; a[0] = a0; a[1] = a1;
        for (int k = 0; k < 2; k++) s[k] = q[k] && (mw[k] >= MAX_WAIT);
        win = -1;
        if (s[0] && s[1])       win = 1 - m_last;
        else if (s[0])          win = 0;
        else if (s[1])          win = 1;
        else if (q[0] && q[1])  win = RR_MODE ? 1 - m_last : 0;
        else if (q[0])          win = 0;
        else if (q[1])          win = 1;
        exp_rom = (win < 0) ? m_last_addr : ((win == 0) ? a[0] : a[1]);
        chk("model_gnt0", {31'b0, m0_gnt}, {31'b0, (win == 0)});
        chk("model_gnt1", {31'b0, m1_gnt}, {31'b0, (win == 1)});
        chk("model_rom_addr", rom_addr, exp_rom);
        act_rv[0] = {31'b0, m0_rvalid}; act_rv[1] = {31'b0, m1_rvalid};
        act_rd[0] = m0_rdata;           act_rd[1] = m1_rdata;
        act_er[0] = {31'b0, m0_err};    act_er[1] = {31'b0, m1_err};
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("model_rvalid%0d", k), act_rv[k], {31'b0, e_rv[k]});
            chk($sformatf("model_rdata%0d", k), act_rd[k], e_rd[k]);
            if (e_rv[k]) chk($sformatf("model_err%0d", k), act_er[k], {31'b0, e_er[k]});
        end
        for (int k = 0; k < 2; k++) begin
            e_rv[k] = (win == k);
            if (win == k) begin
                oor     = ({2'b00, a[k][31:2]} >= 32'(ROM_DEPTH));
                e_er[k] = oor;
                e_rd[k] = oor ? 32'h0000_0013 : rom_fn(a[k]);
            end
            mw[k] = (q[k] && win != k) ? ((mw[k] < 15) ? mw[k] + 1 : 15) : 0;
        end
        if (win >= 0) begin
            m_last      = win;
            m_last_addr = exp_rom;
        end
    endtask

    task automatic run_cycle(input logic q0, input logic [31:0] a0,
                             input logic q1, input logic [31:0] a1, output int win);
        m0_req = q0; m0_addr = a0; m1_req = q1; m1_addr = a1;
        #4;
        model_step(q0, a0, q1, a1, win);
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return $urandom | 32'h0004_0000;
        if (r == 1) return 32'h0003_FFFC | 32'($urandom_range(0, 3));
        return {14'b0, 16'($urandom), 2'($urandom)};
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        q0; logic [31:0] a0;
        logic        q1; logic [31:0] a1;
        logic        g0; logic g1;
        logic [31:0] ra;
        logic        rv0; logic rv1;
        logic [31:0] rd0; logic [31:0] rd1;
        logic        er0; logic er1;
    } vec_t;

    function automatic vec_t mk(input logic q0, input logic [31:0] a0,
                                input logic q1, input logic [31:0] a1,
                                input logic g0, input logic g1, input logic [31:0] ra,
                                input logic rv0, input logic rv1,
                                input logic [31:0] rd0, input logic [31:0] rd1,
                                input logic er0, input logic er1);
        vec_t v;
        v.q0 = q0; v.a0 = a0; v.q1 = q1; v.a1 = a1; v.g0 = g0; v.g1 = g1; v.ra = ra;
        v.rv0 = rv0; v.rv1 = rv1; v.rd0 = rd0; v.rd1 = rd1; v.er0 = er0; v.er1 = er1;
        return v;
    endfunction

    vec_t        tbl[$];
    logic        cq[2];
    logic [31:0] ca[2];
    int          gw;

    initial begin
        localparam logic [31:0] NOP = 32'h0000_0013;
        tbl.push_back(mk(0, 0,     0, 0,        0, 0, 32'h0,     0, 0, 32'h0,        32'h0, 0, 0));
        tbl.push_back(mk(1, 8,     0, 0,        1, 0, 32'h8,     0, 0, 32'h0,        32'h0, 0, 0));
        tbl.push_back(mk(0, 0,     0, 0,        0, 0, 32'h8,     1, 0, 32'h0011_2023, 32'h0, 0, 0));
        tbl.push_back(mk(1, 'h10,  1, 'h20,     1, 0, 32'h10,    0, 0, 32'h0011_2023, 32'h0, 0, 0));
        tbl.push_back(mk(1, 'h14,  1, 'h20,     1, 0, 32'h14,    1, 0, w(4),         32'h0, 0, 0));
        tbl.push_back(mk(1, 'h18,  1, 'h20,     1, 0, 32'h18,    1, 0, w(5),         32'h0, 0, 0));
        tbl.push_back(mk(1, 'h1C,  1, 'h20,     1, 0, 32'h1C,    1, 0, w(6),         32'h0, 0, 0));
        tbl.push_back(mk(1, 'h24,  1, 'h20,     0, 1, 32'h20,    1, 0, w(7),         32'h0, 0, 0));
        tbl.push_back(mk(1, 'h24,  1, 'h40000,  1, 0, 32'h24,    0, 1, w(7),         w(8),  0, 0));
        tbl.push_back(mk(0, 0,     1, 'h40000,  0, 1, 32'h40000, 1, 0, w(9),         w(8),  0, 0));
        tbl.push_back(mk(0, 0,     0, 0,        0, 0, 32'h40000, 0, 1, w(9),         NOP,   0, 1));
        tbl.push_back(mk(1, 0,     0, 0,        1, 0, 32'h0,     0, 0, w(9),         NOP,   0, 0));
        tbl.push_back(mk(1, 4,     0, 0,        1, 0, 32'h4,     1, 0, w(0),         NOP,   0, 0));
        tbl.push_back(mk(1, 8,     0, 0,        1, 0, 32'h8,     1, 0, w(1),         NOP,   0, 0));
        tbl.push_back(mk(1, 'hC,   0, 0,        1, 0, 32'hC,     1, 0, w(2),         NOP,   0, 0));
        tbl.push_back(mk(0, 0,     0, 0,        0, 0, 32'hC,     1, 0, w(3),         NOP,   0, 0));
        tbl.push_back(mk(0, 0,     0, 0,        0, 0, 32'hC,     0, 0, w(3),         NOP,   0, 0));
        tbl.push_back(mk(1, 7,     0, 0,        1, 0, 32'h7,     0, 0, w(3),         NOP,   0, 0));
        tbl.push_back(mk(0, 0,     0, 0,        0, 0, 32'h7,     1, 0, w(1),         NOP,   0, 0));

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_m0_rvalid", {31'b0, m0_rvalid}, 32'd0);
        chk("reset_m1_rvalid", {31'b0, m1_rvalid}, 32'd0);
        chk("reset_m0_rdata", m0_rdata, 32'd0);
        chk("reset_m1_rdata", m1_rdata, 32'd0);
        chk("reset_m0_err", {31'b0, m0_err}, 32'd0);
        chk("reset_m1_err", {31'b0, m1_err}, 32'd0);
        reset_n = 1'b1;

`ifndef ROM_ARB_RR_EN
        // Fixed-priority directed vectors
        for (int i = 0; i < tbl.size(); i++) begin
            m0_req = tbl[i].q0; m0_addr = tbl[i].a0;
            m1_req = tbl[i].q1; m1_addr = tbl[i].a1;
            #4;
            chk($sformatf("t%0d_gnt0", i), {31'b0, m0_gnt}, {31'b0, tbl[i].g0});
            chk($sformatf("t%0d_gnt1", i), {31'b0, m1_gnt}, {31'b0, tbl[i].g1});
            chk($sformatf("t%0d_rom_addr", i), rom_addr, tbl[i].ra);
            chk($sformatf("t%0d_rvalid0", i), {31'b0, m0_rvalid}, {31'b0, tbl[i].rv0});
            chk($sformatf("t%0d_rvalid1", i), {31'b0, m1_rvalid}, {31'b0, tbl[i].rv1});
            chk($sformatf("t%0d_rdata0", i), m0_rdata, tbl[i].rd0);
            chk($sformatf("t%0d_rdata1", i), m1_rdata, tbl[i].rd1);
            if (tbl[i].rv0) chk($sformatf("t%0d_err0", i), {31'b0, m0_err}, {31'b0, tbl[i].er0});
            if (tbl[i].rv1) chk($sformatf("t%0d_err1", i), {31'b0, m1_err}, {31'b0, tbl[i].er1});
            @(posedge clk); #1;
        end
`endif

        // Reset asserted in the cycle after an M1 grant
        m0_req = 1'b0; m1_req = 1'b1; m1_addr = 32'h30;
        #4;
        chk("rst_seq_m1_gnt", {31'b0, m1_gnt}, 32'd1);
        @(posedge clk); #1;
        m1_req = 1'b0;
        chk("rst_seq_m1_rvalid_pre", {31'b0, m1_rvalid}, 32'd1);
        chk("rst_seq_m1_rdata_pre", m1_rdata, w(12));
        reset_n = 1'b0;
        #1;
        chk("rst_seq_m1_rvalid_async", {31'b0, m1_rvalid}, 32'd0);
        chk("rst_seq_m1_rdata_async", m1_rdata, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_seq_m1_rvalid_held", {31'b0, m1_rvalid}, 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_seq_m1_rvalid_after", {31'b0, m1_rvalid}, 32'd0);
        chk("rst_seq_m0_rvalid_after", {31'b0, m0_rvalid}, 32'd0);
        model_reset();

        // Both ports request continuously after reset
        m0_req = 1'b1; m0_addr = 32'h100; m1_req = 1'b1; m1_addr = 32'h204;
        #4;
        chk("post_rst_first_gnt0", {31'b0, m0_gnt}, RR_MODE ? 32'd0 : 32'd1);
        chk("post_rst_first_gnt1", {31'b0, m1_gnt}, RR_MODE ? 32'd1 : 32'd0);
        model_step(1'b1, 32'h100, 1'b1, 32'h204, gw);
        @(posedge clk); #1;
        for (int n = 0; n < 14; n++) run_cycle(1'b1, 32'h100 + 32'(n << 2), 1'b1, 32'h204, gw);
        run_cycle(1'b0, 32'h0, 1'b0, 32'h0, gw);

        // Randomized traffic, respecting the hold-until-grant protocol
        cq[0] = 1'b0; cq[1] = 1'b0; ca[0] = 32'd0; ca[1] = 32'd0; gw = -1;
        for (int n = 0; n < 3000; n++) begin
            for (int k = 0; k < 2; k++) begin
                if (cq[k] && gw != k) begin
                    if ($urandom_range(0, 9) == 0) cq[k] = 1'b0;
                end else begin
                    cq[k] = ($urandom_range(0, 99) < 65);
                    ca[k] = rand_addr();
                end
            end
            run_cycle(cq[0], ca[0], cq[1], ca[1], gw);
        end
        run_cycle(1'b0, 32'h0, 1'b0, 32'h0, gw);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
